// File: rtl/me_acceso_param.sv
// Parametrised PIN access controller: N-digit capture, failure counting and timed lockout.
// Optional inter-digit timeout is compiled in when ME_TIMEOUT_EN is defined.
module me_acceso_param #(
  parameter int N_DIGITOS = 4,
  parameter int W_DIGITO = 4,
  parameter logic [N_DIGITOS*W_DIGITO-1:0] PIN = 16'h6969,
  parameter int MAX_INTENTOS = 3,
  parameter int T_BLOQUEO = 16,
  parameter int T_ESPERA = 32
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SOLICITUD_ACCESO,
  input  logic DIGITO_STB,
  input  logic [W_DIGITO-1:0] DIGITO,
  output logic ACCESO_ACEPTADO,
  output logic ACCESO_DENEGADO,
  output logic BLOQUEO,
  output logic [$clog2(MAX_INTENTOS+1)-1:0] INTENTOS
);

  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int INT_W = $clog2(MAX_INTENTOS + 1);
  localparam int BLQ_W = $clog2(T_BLOQUEO + 1);
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_DIGITOS - 1);
  localparam logic [INT_W-1:0] MAX_I = INT_W'(MAX_INTENTOS);
  localparam logic [BLQ_W-1:0] T_BLQ = BLQ_W'(T_BLOQUEO);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURA,
    ACEPTADO,
    DENEGADO,
    BLOQUEADO
  } estado_t;

  estado_t state, state_next;
  logic stb_q;
  logic evento;
  logic [IDX_W-1:0] indice, indice_next;
  logic fallo, fallo_next;
  logic [INT_W-1:0] intentos, intentos_next, intentos_inc;
  logic [BLQ_W-1:0] bloqueo_cnt, bloqueo_next;
  logic registrar_fallo;
  logic mal;
  logic [W_DIGITO-1:0] pin_dig [N_DIGITOS];

`ifdef ME_TIMEOUT_EN
  localparam int ESP_W = $clog2(T_ESPERA + 1);
  localparam logic [ESP_W-1:0] T_ESP = ESP_W'(T_ESPERA);
  logic [ESP_W-1:0] espera, espera_next;
`endif

  // Digit 0 is the first one typed and maps to the most significant PIN digit.
  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_pin
    assign pin_dig[g] = PIN[(N_DIGITOS-1-g)*W_DIGITO +: W_DIGITO];
  end

  assign evento = DIGITO_STB & ~stb_q;
  assign mal = fallo | (DIGITO != pin_dig[indice]);
  assign intentos_inc = (intentos == MAX_I) ? intentos : intentos + INT_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      stb_q <= 1'b0;
      indice <= '0;
      fallo <= 1'b0;
      intentos <= '0;
      bloqueo_cnt <= '0;
`ifdef ME_TIMEOUT_EN
      espera <= '0;
`endif
    end else begin
      state <= state_next;
      stb_q <= DIGITO_STB;
      indice <= indice_next;
      fallo <= fallo_next;
      intentos <= intentos_next;
      bloqueo_cnt <= bloqueo_next;
`ifdef ME_TIMEOUT_EN
      espera <= espera_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    indice_next = indice;
    fallo_next = fallo;
    intentos_next = intentos;
    bloqueo_next = bloqueo_cnt;
    registrar_fallo = 1'b0;
`ifdef ME_TIMEOUT_EN
    espera_next = espera;
`endif
    case (state)
      IDLE, ACEPTADO, DENEGADO: begin
        if (SOLICITUD_ACCESO) begin
          state_next = CAPTURA;
          indice_next = '0;
          fallo_next = 1'b0;
`ifdef ME_TIMEOUT_EN
          espera_next = T_ESP;
`endif
        end
      end
      CAPTURA: begin
        if (SOLICITUD_ACCESO) begin
          indice_next = '0;
          fallo_next = 1'b0;
`ifdef ME_TIMEOUT_EN
          espera_next = T_ESP;
`endif
        end else if (evento) begin
          if (indice == ULTIMO) begin
            if (mal) begin
              registrar_fallo = 1'b1;
            end else begin
              state_next = ACEPTADO;
              intentos_next = '0;
            end
          end else begin
            indice_next = indice + IDX_W'(1);
            fallo_next = mal;
`ifdef ME_TIMEOUT_EN
            espera_next = T_ESP;
`endif
          end
        end
`ifdef ME_TIMEOUT_EN
        else if (espera <= ESP_W'(1)) begin
          registrar_fallo = 1'b1;
        end else begin
          espera_next = espera - ESP_W'(1);
        end
`endif
      end
      BLOQUEADO: begin
        if (bloqueo_cnt <= BLQ_W'(1)) begin
          state_next = IDLE;
          intentos_next = '0;
          bloqueo_next = '0;
        end else begin
          bloqueo_next = bloqueo_cnt - BLQ_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // The failure that reaches the limit goes straight to lockout, skipping DENEGADO.
    if (registrar_fallo) begin
      intentos_next = intentos_inc;
      if (intentos_inc == MAX_I) begin
        state_next = BLOQUEADO;
        bloqueo_next = T_BLQ;
      end else begin
        state_next = DENEGADO;
      end
    end
  end

  assign ACCESO_ACEPTADO = (state == ACEPTADO);
  assign ACCESO_DENEGADO = (state == DENEGADO) || (state == BLOQUEADO);
  assign BLOQUEO = (state == BLOQUEADO);
  assign INTENTOS = intentos;

endmodule
